sample_packer: RTL

- Downstream neighbour of the barrel-shift compaction stage in the capture datapath.
- Takes compacted samples, whose valid bits are LSB-aligned with a configured bit count per sample, and packs them densely into full DW-bit words for the sample memory/FIFO.
- Packing is LSB-first: earlier samples occupy lower bit positions.
- Provides a flush for partial words at end of capture, and a combinational bypass when disabled.

---
 rtl/sample_packer.sv | 89 ++++++++
 1 files changed

// File: rtl/sample_packer.sv
// Dense LSB-first packer: accumulates variable-width compacted samples into full DW-bit words,
// with flush of partial words and a combinational bypass when disabled.
module sample_packer #(
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctl_clr,
    input  logic                  ctl_ena,
    input  logic                  ctl_flush,
    input  logic [$clog2(DW):0]   cfg_width,
    input  logic                  sti_valid,
    output logic                  sti_ready,
    input  logic [DW-1:0]         sti_data,
    output logic                  sto_valid,
    input  logic                  sto_ready,
    output logic [DW-1:0]         sto_data
);

    localparam int DL = $clog2(DW);
    localparam logic [DL:0] DW_C = (DL+1)'(DW);

    logic [2*DW-1:0] acc_q, acc_d;
    logic [DL:0]     cnt_q, cnt_d;
    logic            flush_q, flush_d;

    logic [DL:0]     w_eff;
    logic [DW-1:0]   mask;
    logic            out_valid, out_xfer, in_ready, in_xfer;
    logic [DL:0]     cnt_ao;
    logic [2*DW-1:0] acc_ao;

    always_comb begin
        w_eff     = (cfg_width == '0 || cfg_width > DW_C) ? DW_C : cfg_width;
        mask      = {DW{1'b1}} >> (DW_C - w_eff);
        out_valid = (cnt_q >= DW_C);
        out_xfer  = ctl_ena & out_valid & sto_ready;
        in_ready  = !flush_q & (!out_valid | sto_ready);
        in_xfer   = ctl_ena & sti_valid & in_ready;
        cnt_ao    = out_xfer ? (cnt_q - DW_C) : cnt_q;
        acc_ao    = out_xfer ? (acc_q >> DW) : acc_q;

        acc_d   = acc_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;

        // Disabled: state is frozen, the datapath runs in bypass.
        if (ctl_ena) begin
            if (ctl_clr) begin
                acc_d   = '0;
                cnt_d   = '0;
                flush_d = 1'b0;
            end else begin
                acc_d = acc_ao | (in_xfer ? ({{DW{1'b0}}, sti_data & mask} << cnt_ao) : '0);
                cnt_d = cnt_ao + (in_xfer ? w_eff : '0);
                if (flush_q) begin
                    // Input is stalled while pending; bits above cnt are already zero,
                    // so raising cnt to DW yields the zero-padded word.
                    if (cnt_q == '0) begin
                        flush_d = 1'b0;
                    end else if (!out_valid) begin
                        cnt_d = DW_C;
                    end else if (out_xfer && cnt_ao == '0) begin
                        flush_d = 1'b0;
                    end
                end else if (ctl_flush) begin
                    flush_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    assign sto_valid = ctl_ena ? out_valid       : sti_valid;
    assign sto_data  = ctl_ena ? acc_q[DW-1:0]   : sti_data;
    assign sti_ready = ctl_ena ? in_ready        : sto_ready;

endmodule
